// File: rtl/qpi_target.sv
// qpi_target: QPI (quad SPI, mode 0) memory-side responder.
// Pad SCK/CS/data are oversampled with clk, command and 24-bit address are
// decoded, and quad reads/writes are served over a byte-wide request/ack bus.
//
// state      | meaning
// -----------|------------------------------------------------------------
// S_IDLE     | CS released; waiting for CS assertion
// S_CMD      | shifting in the two command nibbles
// S_ADDR     | shifting in the six address nibbles
// S_DUMMY    | first byte requested; counting dummy SCK rising edges
// S_RD_DATA  | driving read nibbles on SCK falling edges, prefetching bytes
// S_WR_DATA  | collecting write nibbles; one bus_we per completed byte
// S_IGNORE   | unsupported command; bus and pads stay quiet until CS rises
module qpi_target #(
    parameter int DUMMY_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        qpi_clk,
    input  logic        qpi_cs_n,
    input  logic [3:0]  qpi_io_i,
    output logic [3:0]  qpi_io_o,
    output logic [3:0]  qpi_io_oe,
    output logic [23:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack,
    output logic        busy,
    output logic        err_late
);

    localparam int DW = $clog2(DUMMY_CYCLES + 1);
    localparam logic [DW-1:0] DUMMY_LOAD = DW'(DUMMY_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RD_DATA,
        S_WR_DATA,
        S_IGNORE
    } state_t;

    logic [1:0] sck_sync;
    logic [1:0] cs_sync;
    logic [3:0] io_meta;
    logic [3:0] io_sync;
    logic       sck_hist;
    logic       cs_hist;

    logic       sck_rise;
    logic       sck_fall;
    logic       cs_rise;
    logic       cs_fall;

    state_t     state;
    logic [2:0] nib_cnt;
    logic [3:0] cmd_hi;
    logic [19:0] addr_sr;
    logic       is_read;
    logic [23:0] cur_addr;
    logic [DW-1:0] dummy_cnt;
    logic [7:0] hold;
    logic       hold_fresh;
    logic [3:0] lo_nib;
    logic       rd_hi_next;
    logic [3:0] wr_hi;
    logic       wr_lo_next;

    logic [7:0]  cmd_byte;
    logic [23:0] addr_full;
    logic [23:0] addr_inc;

    // Two-flop synchronizers, plus one history stage on SCK and CS for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= 2'b00;
            cs_sync  <= 2'b11;
            io_meta  <= 4'h0;
            io_sync  <= 4'h0;
            sck_hist <= 1'b0;
            cs_hist  <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[0], qpi_clk};
            cs_sync  <= {cs_sync[0], qpi_cs_n};
            io_meta  <= qpi_io_i;
            io_sync  <= io_meta;
            sck_hist <= sck_sync[1];
            cs_hist  <= cs_sync[1];
        end
    end

    assign sck_rise  = sck_sync[1] & ~sck_hist;
    assign sck_fall  = ~sck_sync[1] & sck_hist;
    assign cs_rise   = cs_sync[1] & ~cs_hist;
    assign cs_fall   = ~cs_sync[1] & cs_hist;

    assign cmd_byte  = {cmd_hi, io_sync};
    assign addr_full = {addr_sr, io_sync};
    assign addr_inc  = cur_addr + 24'd1;

    // Protocol state machine; all pad and bus outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            nib_cnt    <= 3'd0;
            cmd_hi     <= 4'h0;
            addr_sr    <= 20'h0;
            is_read    <= 1'b0;
            cur_addr   <= 24'h0;
            dummy_cnt  <= '0;
            hold       <= 8'h0;
            hold_fresh <= 1'b0;
            lo_nib     <= 4'h0;
            rd_hi_next <= 1'b1;
            wr_hi      <= 4'h0;
            wr_lo_next <= 1'b0;
            qpi_io_o   <= 4'h0;
            qpi_io_oe  <= 4'h0;
            bus_addr   <= 24'h0;
            bus_wdata  <= 8'h0;
            bus_we     <= 1'b0;
            bus_re     <= 1'b0;
            busy       <= 1'b0;
            err_late   <= 1'b0;
        end else begin
            bus_we <= 1'b0;
            bus_re <= 1'b0;

            // Acks only matter while a read is live; stragglers after CS release are dropped
            if (bus_ack && (state == S_DUMMY || state == S_RD_DATA)) begin
                hold       <= bus_rdata;
                hold_fresh <= 1'b1;
            end

            if (cs_rise) begin
                state      <= S_IDLE;
                qpi_io_oe  <= 4'h0;
                busy       <= 1'b0;
                wr_lo_next <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state      <= S_CMD;
                            nib_cnt    <= 3'd1;
                            busy       <= 1'b1;
                            err_late   <= 1'b0;
                            hold_fresh <= 1'b0;
                        end
                    end

                    S_CMD: begin
                        if (sck_rise) begin
                            if (nib_cnt == 3'd0) begin
                                nib_cnt <= 3'd5;
                                if (cmd_byte == 8'hEB) begin
                                    is_read <= 1'b1;
                                    state   <= S_ADDR;
                                end else if (cmd_byte == 8'h38 || cmd_byte == 8'h02) begin
                                    is_read <= 1'b0;
                                    state   <= S_ADDR;
                                end else begin
                                    state   <= S_IGNORE;
                                end
                            end else begin
                                cmd_hi  <= io_sync;
                                nib_cnt <= nib_cnt - 3'd1;
                            end
                        end
                    end

                    S_ADDR: begin
                        if (sck_rise) begin
                            if (nib_cnt == 3'd0) begin
                                cur_addr <= addr_full;
                                bus_addr <= addr_full;
                                if (is_read) begin
                                    bus_re     <= 1'b1;
                                    hold_fresh <= 1'b0;
                                    dummy_cnt  <= DUMMY_LOAD;
                                    state      <= S_DUMMY;
                                end else begin
                                    wr_lo_next <= 1'b0;
                                    state      <= S_WR_DATA;
                                end
                            end else begin
                                addr_sr <= {addr_sr[15:0], io_sync};
                                nib_cnt <= nib_cnt - 3'd1;
                            end
                        end
                    end

                    S_DUMMY: begin
                        if (sck_rise) begin
                            if (dummy_cnt == DW'(1)) begin
                                rd_hi_next <= 1'b1;
                                state      <= S_RD_DATA;
                            end else begin
                                dummy_cnt <= dummy_cnt - DW'(1);
                            end
                        end
                    end

                    S_RD_DATA: begin
                        if (sck_fall) begin
                            qpi_io_oe <= 4'hF;
                            if (rd_hi_next) begin
                                // Latch the whole byte now so a prefetch ack cannot corrupt the low nibble
                                qpi_io_o   <= hold[7:4];
                                lo_nib     <= hold[3:0];
                                if (!hold_fresh) begin
                                    err_late <= 1'b1;
                                end
                                hold_fresh <= 1'b0;
                                cur_addr   <= addr_inc;
                                bus_addr   <= addr_inc;
                                bus_re     <= 1'b1;
                                rd_hi_next <= 1'b0;
                            end else begin
                                qpi_io_o   <= lo_nib;
                                rd_hi_next <= 1'b1;
                            end
                        end
                    end

                    S_WR_DATA: begin
                        if (sck_rise) begin
                            if (!wr_lo_next) begin
                                wr_hi      <= io_sync;
                                wr_lo_next <= 1'b1;
                            end else begin
                                bus_wdata  <= {wr_hi, io_sync};
                                bus_addr   <= cur_addr;
                                bus_we     <= 1'b1;
                                cur_addr   <= addr_inc;
                                wr_lo_next <= 1'b0;
                            end
                        end
                    end

                    S_IGNORE: begin
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
